// File: rtl/cbf_buf_pkg.sv
// Shared types for the lookahead batch buffer: bank count, bank index
// type, read-engine state encoding and bank rotation helpers.
package cbf_buf_pkg;

    localparam int NUM_BANKS = 3;

    typedef logic [1:0] bank_idx_t;

    typedef enum logic {
        IDLE = 1'b0,
        READ = 1'b1
    } rd_state_t;

    // Next bank in the 0 -> 1 -> 2 -> 0 rotation.
    function automatic bank_idx_t bank_next(input bank_idx_t b);
        return (b == 2'd2) ? 2'd0 : b + 2'd1;
    endfunction

    // Previous bank in the rotation, i.e. (b - 1) mod 3.
    function automatic bank_idx_t bank_prev(input bank_idx_t b);
        return (b == 2'd0) ? 2'd2 : b - 2'd1;
    endfunction

endpackage

// File: rtl/lookahead_batch_buffer_ram.sv
// BatchBankRam: three banks of `depth` words, one write port and two
// registered read ports sharing one address (compute and lookahead bank).
//
// Ports:
//   clk, rst        clock, async active-high reset (read registers only)
//   we_i            write enable
//   wbank_i/waddr_i write bank / word address
//   wdata_i         write data
//   re_i            read enable; read registers hold when low
//   rbank_a_i       bank for read port A (compute)
//   rbank_b_i       bank for read port B (lookahead)
//   raddr_i         word address shared by both read ports
//   rdata_a_o       registered read data, port A
//   rdata_b_o       registered read data, port B
module BatchBankRam
    import cbf_buf_pkg::*;
#(
    parameter int W     = 48,
    parameter int DEPTH = 64,
    localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we_i,
    input  bank_idx_t     wbank_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [W-1:0]  wdata_i,
    input  logic          re_i,
    input  bank_idx_t     rbank_a_i,
    input  bank_idx_t     rbank_b_i,
    input  logic [AW-1:0] raddr_i,
    output logic [W-1:0]  rdata_a_o,
    output logic [W-1:0]  rdata_b_o
);

    logic [W-1:0] mem [NUM_BANKS][DEPTH];

    logic [W-1:0] rdata_a_q;
    logic [W-1:0] rdata_b_q;

    // Storage array is deliberately not reset.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem[wbank_i][waddr_i] <= wdata_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_a_q <= '0;
            rdata_b_q <= '0;
        end else if (re_i) begin
            rdata_a_q <= mem[rbank_a_i][raddr_i];
            rdata_b_q <= mem[rbank_b_i][raddr_i];
        end
    end

    assign rdata_a_o = rdata_a_q;
    assign rdata_b_o = rdata_b_q;

endmodule

// File: rtl/lookahead_batch_buffer.sv
// Batch sample buffer: writes samples into three rotating banks and
// replays each finished batch backwards together with its successor.
//
// Ports:
//   clk, rst         clock, async active-high reset
//   sampleIn         incoming sample word (M*DSR bits)
//   sampleValid      sampleIn written on this edge
//   readEn           read engine advances only when high
//   inSample         word from the compute bank
//   lookaheadSample  word from the lookahead bank, same address
//   validOut         output words valid this cycle
//   batchStart       pulse with the first word of a batch
//   overrun          sticky dropped-batch flag (only with CBF_BUF_OVERRUN_EN)
//
// Optional feature macro: CBF_BUF_OVERRUN_EN adds the overrun port.
module lookahead_batch_buffer
    import cbf_buf_pkg::*;
#(
    parameter int M     = 4,
    parameter int DSR   = 12,
    parameter int depth = 64,
    localparam int SampleWidth = M * DSR,
    localparam int AW = (depth > 1) ? $clog2(depth) : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [SampleWidth-1:0] sampleIn,
    input  logic                   sampleValid,
    input  logic                   readEn,
    output logic [SampleWidth-1:0] inSample,
    output logic [SampleWidth-1:0] lookaheadSample,
    output logic                   validOut,
    output logic                   batchStart
`ifdef CBF_BUF_OVERRUN_EN
   ,output logic                   overrun
`endif
);

    localparam logic [AW-1:0] LAST_ADDR = AW'(depth - 1);

    // Write side
    logic [AW-1:0] wrAddr_q;
    logic [AW-1:0] wrAddr_d;
    bank_idx_t     wrBank_q;
    bank_idx_t     wrBank_d;
    logic          primed_q;
    logic          primed_d;
    logic          fill;

    // Batch request, registered one edge after the filling write
    logic          req_q;
    bank_idx_t     reqCmp_q;
    bank_idx_t     reqLa_q;

    // Read engine
    rd_state_t     state_q;
    logic [AW-1:0] rdAddr_q;
    bank_idx_t     cmpBank_q;
    bank_idx_t     laBank_q;
    logic          validOut_q;
    logic          batchStart_q;
    logic          rdIssue;
    logic          rdLast;

    assign fill = sampleValid && (wrAddr_q == LAST_ADDR);

    always_comb begin
        wrAddr_d = wrAddr_q;
        wrBank_d = wrBank_q;
        primed_d = primed_q;
        if (sampleValid) begin
            if (fill) begin
                wrAddr_d = '0;
                wrBank_d = bank_next(wrBank_q);
                primed_d = 1'b1;
            end else begin
                wrAddr_d = wrAddr_q + AW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wrAddr_q <= '0;
            wrBank_q <= '0;
            primed_q <= 1'b0;
            req_q    <= 1'b0;
            reqCmp_q <= '0;
            reqLa_q  <= '0;
        end else begin
            wrAddr_q <= wrAddr_d;
            wrBank_q <= wrBank_d;
            primed_q <= primed_d;
            // The very first fill only primes; a batch needs a
            // predecessor bank to act as its compute bank.
            req_q    <= fill && primed_q;
            reqCmp_q <= bank_prev(wrBank_q);
            reqLa_q  <= wrBank_q;
        end
    end

    assign rdIssue = (state_q == READ) && readEn;
    assign rdLast  = rdIssue && (rdAddr_q == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            rdAddr_q     <= '0;
            cmpBank_q    <= '0;
            laBank_q     <= '0;
            validOut_q   <= 1'b0;
            batchStart_q <= 1'b0;
        end else begin
            validOut_q   <= rdIssue;
            batchStart_q <= rdIssue && (rdAddr_q == LAST_ADDR);
            unique case (state_q)
                IDLE: begin
                    if (req_q) begin
                        state_q   <= READ;
                        rdAddr_q  <= LAST_ADDR;
                        cmpBank_q <= reqCmp_q;
                        laBank_q  <= reqLa_q;
                    end
                end
                READ: begin
                    if (rdLast) begin
                        // A request landing on the final read chains
                        // straight into the next batch without a gap.
                        if (req_q) begin
                            rdAddr_q  <= LAST_ADDR;
                            cmpBank_q <= reqCmp_q;
                            laBank_q  <= reqLa_q;
                        end else begin
                            state_q <= IDLE;
                        end
                    end else if (rdIssue) begin
                        rdAddr_q <= rdAddr_q - AW'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign validOut   = validOut_q;
    assign batchStart = batchStart_q;

`ifdef CBF_BUF_OVERRUN_EN
    logic overrun_q;

    // Request arriving mid-batch is dropped; remember it until reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overrun_q <= 1'b0;
        end else if (req_q && (state_q == READ) && !rdLast) begin
            overrun_q <= 1'b1;
        end
    end

    assign overrun = overrun_q;
`endif

    BatchBankRam #(
        .W     (SampleWidth),
        .DEPTH (depth)
    ) u_ram (
        .clk       (clk),
        .rst       (rst),
        .we_i      (sampleValid),
        .wbank_i   (wrBank_q),
        .waddr_i   (wrAddr_q),
        .wdata_i   (sampleIn),
        .re_i      (rdIssue),
        .rbank_a_i (cmpBank_q),
        .rbank_b_i (laBank_q),
        .raddr_i   (rdAddr_q),
        .rdata_a_o (inSample),
        .rdata_b_o (lookaheadSample)
    );

endmodule

// File: tb/tb_lookahead_batch_buffer.sv
// Scoreboard bench for lookahead_batch_buffer (M=2, DSR=2, depth=4).
// Reference model: list of accepted words; batch k pairs words of fills k-1, k.
module tb_lookahead_batch_buffer;

    localparam int M     = 2;
    localparam int DSR   = 2;
    localparam int DEPTH = 4;
    localparam int W     = M * DSR;

    logic         clk;
    logic         rst;
    logic [W-1:0] sampleIn;
    logic         sampleValid;
    logic         readEn;
    logic [W-1:0] inSample;
    logic [W-1:0] lookaheadSample;
    logic         validOut;
    logic         batchStart;
`ifdef CBF_BUF_OVERRUN_EN
    logic         overrun;
`endif

    lookahead_batch_buffer #(
        .M     (M),
        .DSR   (DSR),
        .depth (DEPTH)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .sampleIn        (sampleIn),
        .sampleValid     (sampleValid),
        .readEn          (readEn),
        .inSample        (inSample),
        .lookaheadSample (lookaheadSample),
        .validOut        (validOut),
        .batchStart      (batchStart)
`ifdef CBF_BUF_OVERRUN_EN
       ,.overrun         (overrun)
`endif
    );

    typedef struct {
        logic [W-1:0] in;
        logic [W-1:0] la;
        logic         start;
        int           start_edge;
    } exp_t;

    exp_t         exp_q[$];
    logic [W-1:0] words[$];
    int           errors = 0;
    int           checks = 0;
    int           cyc = 0;
    bit           expect_drop = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    // Called when a bank fill completes; builds the reversed batch.
    task automatic model_fill(input logic re);
        int   k;
        exp_t e;
        k = words.size() / DEPTH;
        if (expect_drop) begin
            expect_drop = 0;
        end else begin
            for (int i = DEPTH - 1; i >= 0; i--) begin
                e.in         = words[(k - 2) * DEPTH + i];
                e.la         = words[(k - 1) * DEPTH + i];
                e.start      = (i == DEPTH - 1);
                e.start_edge = re ? cyc + 2 : -1;
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic step(input logic v, input logic [W-1:0] d,
                        input logic re);
        sampleValid = v;
        sampleIn    = d;
        readEn      = re;
        @(posedge clk);
        #1;
        if (v) begin
            words.push_back(d);
            if ((words.size() % DEPTH) == 0 && words.size() >= 2 * DEPTH)
                model_fill(re);
        end
    endtask

    task automatic check_zero_outputs();
        chk("rst_validOut", {31'd0, validOut}, 32'd0);
        chk("rst_batchStart", {31'd0, batchStart}, 32'd0);
        chk("rst_inSample", {28'd0, inSample}, 32'd0);
        chk("rst_lookahead", {28'd0, lookaheadSample}, 32'd0);
`ifdef CBF_BUF_OVERRUN_EN
        chk("rst_overrun", {31'd0, overrun}, 32'd0);
`endif
    endtask

    // Asserted mid-cycle, away from any clock edge.
    task automatic do_reset();
        sampleValid = 1'b0;
        readEn      = 1'b1;
        #1;
        rst = 1'b1;
        #1;
        check_zero_outputs();
        words.delete();
        exp_q.delete();
        expect_drop = 0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Monitor / scoreboard
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (validOut) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_valid: got in=%0h la=%0h required no output (cycle %0d)",
                             inSample, lookaheadSample, cyc);
                end else begin
                    e = exp_q.pop_front();
                    if (inSample !== e.in || lookaheadSample !== e.la ||
                        batchStart !== e.start) begin
                        errors++;
                        $display("FAIL batch_word: got in=%0h la=%0h start=%0b required in=%0h la=%0h start=%0b (cycle %0d)",
                                 inSample, lookaheadSample, batchStart,
                                 e.in, e.la, e.start, cyc);
                    end
                    if (e.start && e.start_edge >= 0) begin
                        checks++;
                        if (cyc != e.start_edge) begin
                            errors++;
                            $display("FAIL start_timing: got edge %0d required edge %0d",
                                     cyc, e.start_edge);
                        end
                    end
                end
            end else if (batchStart) begin
                checks++;
                errors++;
                $display("FAIL start_without_valid: got batchStart=1 required 0 (cycle %0d)", cyc);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] d;
        logic         v;
        rst         = 1'b0;
        sampleValid = 1'b0;
        sampleIn    = '0;
        readEn      = 1'b1;
        @(posedge clk);
        #1;

        // Reset mid-cycle, then two back-to-back batches with timing
        do_reset();
        for (int n = 1; n <= 18; n++) begin
            if (n <= 12) step(1'b1, W'(n), 1'b1);
            else         step(1'b0, '0, 1'b1);
            chk("valid_timing", {31'd0, validOut},
                {31'd0, (n >= 10 && n <= 17)});
        end
        chk("drain_b2b", exp_q.size(), 0);

        // Same data with sampleValid toggling
        do_reset();
        for (int n = 1; n <= 24; n++) begin
            if (n % 2 == 1) step(1'b1, W'((n + 1) / 2), 1'b1);
            else            step(1'b0, '0, 1'b1);
        end
        repeat (12) step(1'b0, '0, 1'b1);
        chk("drain_toggle", exp_q.size(), 0);

        // readEn stall for two cycles after the second word
        do_reset();
        for (int n = 1; n <= 8; n++) step(1'b1, W'(n), 1'b1);
        repeat (3) step(1'b0, '0, 1'b1);
        step(1'b0, '0, 1'b0);
        chk("stall_valid0", {31'd0, validOut}, 32'd0);
        step(1'b0, '0, 1'b0);
        chk("stall_valid1", {31'd0, validOut}, 32'd0);
        step(1'b0, '0, 1'b1);
        chk("resume_valid0", {31'd0, validOut}, 32'd1);
        step(1'b0, '0, 1'b1);
        chk("resume_valid1", {31'd0, validOut}, 32'd1);
        step(1'b0, '0, 1'b1);
        chk("stall_end", {31'd0, validOut}, 32'd0);
        chk("drain_stall", exp_q.size(), 0);

        // Randomized stream, readEn held high
        do_reset();
        for (int n = 0; n < 300; n++) begin
            v = ($urandom_range(0, 3) != 0);
            d = W'($urandom);
            step(v, d, 1'b1);
        end
        repeat (12) step(1'b0, '0, 1'b1);
        chk("drain_random", exp_q.size(), 0);

        // Dropped batch while stalled, then reset mid-batch
        do_reset();
        for (int n = 1; n <= 8; n++) step(1'b1, W'(n), 1'b0);
        expect_drop = 1;
        for (int n = 9; n <= 12; n++) step(1'b1, W'(n), 1'b0);
        step(1'b0, '0, 1'b0);
        chk("stalled_no_valid", {31'd0, validOut}, 32'd0);
`ifdef CBF_BUF_OVERRUN_EN
        chk("overrun_set", {31'd0, overrun}, 32'd1);
`endif
        repeat (6) step(1'b0, '0, 1'b1);
        for (int n = 13; n <= 16; n++) step(1'b1, W'(n), 1'b1);
        repeat (6) step(1'b0, '0, 1'b1);
        for (int n = 17; n <= 20; n++) step(1'b1, W'(n), 1'b1);
        repeat (3) step(1'b0, '0, 1'b1);
        chk("midbatch_valid", {31'd0, validOut}, 32'd1);
        do_reset();
        for (int n = 21; n <= 24; n++) step(1'b1, W'(n), 1'b1);
        repeat (6) step(1'b0, '0, 1'b1);
        chk("primed_only_no_batch", exp_q.size(), 0);
        for (int n = 25; n <= 28; n++) step(1'b1, W'(n), 1'b1);
        repeat (8) step(1'b0, '0, 1'b1);
        chk("drain_after_reset", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
